// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: a + b + cin computed CHUNK bits per clock, LSB slice first,
// with valid/ready handshakes on both sides and ALU-style result flags.
module chunk_serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             signed_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] final_sum,
    output logic             cout,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              signed_q;

    logic [CHUNK:0]    slice_c;
    logic [WIDTH-1:0]  sum_c;
    logic              last_c;
    logic              accept_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the current slice add; sum_c is the sum with this slice merged in
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = (cnt == CNT_W'(NCHUNK - 1));
        slice_c    = {1'b0, a_q[cnt*CHUNK +: CHUNK]}
                   + {1'b0, b_q[cnt*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};
        sum_c      = sum_q;
        sum_c[cnt*CHUNK +: CHUNK] = slice_c[CHUNK-1:0];

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, slice accumulation and registered result/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            carry_q       <= 1'b0;
            signed_q      <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            final_sum     <= '0;
            cout          <= 1'b0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);

            if (accept_c) begin
                a_q      <= a;
                b_q      <= b;
                carry_q  <= cin;
                signed_q <= signed_en;
                cnt      <= '0;
                sum_q    <= '0;
            end

            if (state == S_RUN) begin
                sum_q   <= sum_c;
                carry_q <= slice_c[CHUNK];
                cnt     <= cnt + CNT_W'(1);
                if (last_c) begin
                    final_sum     <= sum_c;
                    cout          <= slice_c[CHUNK];
                    zero_flag     <= (sum_c == '0);
                    negative_flag <= signed_q & sum_c[MSB];
                    overflow_flag <= signed_q
                                   ? ((a_q[MSB] == b_q[MSB]) && (sum_c[MSB] != a_q[MSB]))
                                   : slice_c[CHUNK];
                end
            end
        end
    end

endmodule
